// File: rtl/blake2_pkg.sv
// Shared constants for the BLAKE2 round scheduler: message permutation,
// G step word indices, rotation amounts and the control FSM encoding.
package blake2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Each row lists message word indices left to right; element [0] is the
  // leftmost nibble of the literal.
  localparam logic [0:15][3:0] SIGMA [10] = '{
    64'h0123456789ABCDEF,
    64'hEA489FD61C02B753,
    64'hB8C052FDAE367194,
    64'h7931DCBE265A40F8,
    64'h905724AFE1BC683D,
    64'h2C6A0B834D75FE19,
    64'hC51FED4A0763928B,
    64'hDB7EC13950F4862A,
    64'h6FE9B308C2D714A5,
    64'hA2847615FB9E3CD0
  };

  // (a,b,c,d) working-vector indices: four column steps, then four diagonals.
  localparam logic [0:3][3:0] G_IDX [8] = '{
    16'h048C, 16'h159D, 16'h26AE, 16'h37BF,
    16'h05AF, 16'h16BC, 16'h278D, 16'h349E
  };

  localparam int R1_S = 16;
  localparam int R2_S = 12;
  localparam int R3_S = 8;
  localparam int R4_S = 7;

  localparam int R1_B = 32;
  localparam int R2_B = 24;
  localparam int R3_B = 16;
  localparam int R4_B = 63;

endpackage

// File: rtl/blake2_round_sched_if.sv
// Block-level bus of the round scheduler: input block handshake, output
// vector handshake and the round/step debug taps.
interface blake2_round_sched_if #(
    parameter int W = 32
);
  // Both handshakes: a transfer happens on a rising clk edge where valid and
  // ready are both high; the sender holds its data stable while valid is high
  // and ready is low, and ready never waits on valid in the same cycle.
  logic                valid_i;
  logic                ready_o;
  logic [15:0][W-1:0]  v_i;
  logic [15:0][W-1:0]  m_i;
  logic                valid_o;
  logic                ready_i;
  logic [15:0][W-1:0]  v_o;
  logic [3:0]          round_o;
  logic [2:0]          step_o;

  modport master (
    output valid_i, v_i, m_i, ready_i,
    input  ready_o, valid_o, v_o, round_o, step_o
  );

  modport slave (
    input  valid_i, v_i, m_i, ready_i,
    output ready_o, valid_o, v_o, round_o, step_o
  );

endinterface

// File: rtl/blake2_g_step.sv
// One combinational BLAKE2 G evaluation on four working words plus two
// message words.
module blake2_g_step #(
    parameter int W  = 32,
    parameter int R1 = 16,
    parameter int R2 = 12,
    parameter int R3 = 8,
    parameter int R4 = 7
) (
    input  logic [W-1:0] va,
    input  logic [W-1:0] vb,
    input  logic [W-1:0] vc,
    input  logic [W-1:0] vd,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] oa,
    output logic [W-1:0] ob,
    output logic [W-1:0] oc,
    output logic [W-1:0] od
);

  function automatic logic [W-1:0] rotr(input logic [W-1:0] val, input int n);
    return (val >> n) | (val << (W - n));
  endfunction

  logic [W-1:0] a1, b1, c1, d1;

  always_comb begin
    a1 = va + vb + x;
    d1 = rotr(vd ^ a1, R1);
    c1 = vc + d1;
    b1 = rotr(vb ^ c1, R2);
    oa = a1 + b1 + y;
    od = rotr(d1 ^ oa, R3);
    oc = c1 + od;
    ob = rotr(b1 ^ oc, R4);
  end

endmodule

// File: rtl/blake2_round_sched.sv
// Iterative BLAKE2 compression rounds: owns v and m, applies one G step per
// clock, 8 steps per round, and hands the mixed vector to the finaliser.
module blake2_round_sched
  import blake2_pkg::*;
#(
    parameter int W      = 32,
    parameter int ROUNDS = 10,
    parameter int R1     = R1_S,
    parameter int R2     = R2_S,
    parameter int R3     = R3_S,
    parameter int R4     = R4_S
) (
    input logic                 clk,
    input logic                 nreset,
    blake2_round_sched_if.slave bus
);

  state_t             state_q, state_d;
  logic [15:0][W-1:0] v_q, m_q;
  logic [3:0]         round_q;
  logic [2:0]         step_q;

  logic [3:0]         row;
  logic [3:0]         ia, ib, ic, id, ix, iy;
  logic [W-1:0]       oa, ob, oc, od;
  logic               accept, last_step;

  assign accept    = (state_q == IDLE) && bus.valid_i;
  assign last_step = (step_q == 3'd7) && (round_q == 4'(ROUNDS - 1));

  // Rounds 10 and 11 (BLAKE2b) reuse permutation rows 0 and 1.
  always_comb begin
    row = (round_q >= 4'd10) ? (round_q - 4'd10) : round_q;
    ia  = G_IDX[step_q][0];
    ib  = G_IDX[step_q][1];
    ic  = G_IDX[step_q][2];
    id  = G_IDX[step_q][3];
    ix  = SIGMA[row][{step_q, 1'b0}];
    iy  = SIGMA[row][{step_q, 1'b1}];
  end

  blake2_g_step #(
    .W (W),
    .R1(R1),
    .R2(R2),
    .R3(R3),
    .R4(R4)
  ) u_g_step (
    .va(v_q[ia]),
    .vb(v_q[ib]),
    .vc(v_q[ic]),
    .vd(v_q[id]),
    .x (m_q[ix]),
    .y (m_q[iy]),
    .oa(oa),
    .ob(ob),
    .oc(oc),
    .od(od)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.valid_i) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (bus.ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready_o = 1'b0;
    bus.valid_o = 1'b0;
    case (state_q)
      IDLE:    bus.ready_o = 1'b1;
      DONE:    bus.valid_o = 1'b1;
      default: ;
    endcase
  end

  // Counters freeze on the final step so DONE keeps showing the last step.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      v_q     <= '0;
      m_q     <= '0;
      round_q <= '0;
      step_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            v_q     <= bus.v_i;
            m_q     <= bus.m_i;
            round_q <= '0;
            step_q  <= '0;
          end
        end
        RUN: begin
          v_q[ia] <= oa;
          v_q[ib] <= ob;
          v_q[ic] <= oc;
          v_q[id] <= od;
          if (!last_step) begin
            step_q <= step_q + 3'd1;
            if (step_q == 3'd7) round_q <= round_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.v_o     = v_q;
  assign bus.round_o = round_q;
  assign bus.step_o  = step_q;

endmodule

// File: tb/tb_blake2_round_sched.sv
// Directed bench for blake2_round_sched (BLAKE2s configuration) with a
// reference compression model feeding an expected-result queue.
module tb_blake2_round_sched;

  typedef logic [511:0] blk_t;

  logic clk = 1'b0;
  logic nreset;

  always #5 clk = ~clk;

  blake2_round_sched_if #(.W(32)) bus ();

  blake2_round_sched #(
    .W     (32),
    .ROUNDS(10),
    .R1    (16),
    .R2    (12),
    .R3    (8),
    .R4    (7)
  ) dut (
    .clk   (clk),
    .nreset(nreset),
    .bus   (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  blk_t exp_q[$];

  localparam int SIG_T [10][16] = '{
    '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
    '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
    '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
    '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
    '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
    '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
    '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
    '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
    '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
    '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
  };

  localparam logic [31:0] IV [8] = '{
    32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
    32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic blk_t model(input blk_t vin, input blk_t min);
    logic [31:0] v[16];
    logic [31:0] m[16];
    blk_t        res;
    int          a, b, c, d, i;
    for (int k = 0; k < 16; k++) begin
      v[k] = vin[32*k +: 32];
      m[k] = min[32*k +: 32];
    end
    for (int r = 0; r < 10; r++) begin
      for (int s = 0; s < 8; s++) begin
        i = s % 4;
        a = i;
        if (s < 4) begin
          b = 4 + i;
          c = 8 + i;
          d = 12 + i;
        end else begin
          b = 4 + (i + 1) % 4;
          c = 8 + (i + 2) % 4;
          d = 12 + (i + 3) % 4;
        end
        v[a] = v[a] + v[b] + m[SIG_T[r % 10][2*s]];
        v[d] = rotr(v[d] ^ v[a], 16);
        v[c] = v[c] + v[d];
        v[b] = rotr(v[b] ^ v[c], 12);
        v[a] = v[a] + v[b] + m[SIG_T[r % 10][2*s+1]];
        v[d] = rotr(v[d] ^ v[a], 8);
        v[c] = v[c] + v[d];
        v[b] = rotr(v[b] ^ v[c], 7);
      end
    end
    for (int k = 0; k < 16; k++) res[32*k +: 32] = v[k];
    return res;
  endfunction

  function automatic blk_t rand_blk();
    blk_t r;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string tag, input blk_t obs, input blk_t exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    nreset = 1'b0;
    #1;
    check("rst_ready_o", blk_t'(bus.ready_o), 1);
    check("rst_valid_o", blk_t'(bus.valid_o), 0);
    check("rst_v_o", bus.v_o, 0);
    check("rst_round_o", blk_t'(bus.round_o), 0);
    check("rst_step_o", blk_t'(bus.step_o), 0);
  endtask

  // Called at a falling edge while the DUT is idle; returns just after the
  // accepting rising edge.
  task automatic start_block(input blk_t v, input blk_t m);
    check("ready_before_accept", blk_t'(bus.ready_o), 1);
    bus.valid_i = 1'b1;
    bus.v_i     = v;
    bus.m_i     = m;
    exp_q.push_back(model(v, m));
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
  endtask

  task automatic wait_done(input bit sched, input bit pulse);
    int lat = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (pulse) begin
        bus.valid_i = (n % 7 == 3);
        bus.v_i     = rand_blk();
        bus.m_i     = rand_blk();
      end
      if (bus.valid_o) begin
        lat = n;
        break;
      end
      if (sched) begin
        check("step_o", blk_t'(bus.step_o), blk_t'(n % 8));
        check("round_o", blk_t'(bus.round_o), blk_t'(n / 8));
      end
    end
    bus.valid_i = 1'b0;
    check("latency", blk_t'(lat), 80);
  endtask

  task automatic finish_block(input int hold, input bit pulse, output blk_t got);
    blk_t held;
    held = bus.v_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (pulse) bus.valid_i = i[0];
      check("hold_valid_o", blk_t'(bus.valid_o), 1);
      check("hold_v_o", bus.v_o, held);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    got = bus.v_o;
    if (exp_q.size() > 0) begin
      check("v_o", got, exp_q.pop_front());
    end else begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue required one entry");
    end
    @(negedge clk);
    bus.ready_i = 1'b0;
    check("ready_o_after_done", blk_t'(bus.ready_o), 1);
    check("valid_o_after_done", blk_t'(bus.valid_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    blk_t got, vk, mk, ms;
    logic [31:0] h0;

    nreset      = 1'b1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.v_i     = '0;
    bus.m_i     = '0;

    #3;
    apply_reset();
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    check("idle_ready_o", blk_t'(bus.ready_o), 1);
    check("idle_valid_o", blk_t'(bus.valid_o), 0);
    check("idle_v_o", bus.v_o, 0);

    // All-zero block: every G step maps zeros to zeros.
    start_block('0, '0);
    wait_done(1'b0, 1'b0);
    finish_block(0, 1'b0, got);
    check("zero_block", got, 0);

    // Known answer: BLAKE2s("abc"), accepted the cycle ready_o returns.
    vk = '0;
    for (int k = 0; k < 8; k++) begin
      vk[32*k +: 32]     = IV[k];
      vk[32*(k+8) +: 32] = IV[k];
    end
    vk[31:0]             = 32'h6B08E647;
    vk[32*12 +: 32]      = IV[4] ^ 32'd3;
    vk[32*14 +: 32]      = ~IV[6];
    mk                   = '0;
    mk[31:0]             = 32'h00636261;
    start_block(vk, mk);
    wait_done(1'b0, 1'b1);
    finish_block(20, 1'b1, got);
    h0 = 32'h6B08E647 ^ got[31:0] ^ got[32*8 +: 32];
    check("kat_h0", blk_t'(h0), blk_t'(32'h8C5E8C50));

    // Schedule walk with distinct message words.
    ms = '0;
    for (int k = 0; k < 16; k++) ms[32*k +: 32] = 32'(k + 1);
    start_block('0, ms);
    wait_done(1'b1, 1'b0);
    finish_block(2, 1'b0, got);

    // Reset at round 4 step 3; the partial result is discarded.
    start_block(rand_blk(), rand_blk());
    repeat (36) @(negedge clk);
    check("mid_round_o", blk_t'(bus.round_o), 4);
    check("mid_step_o", blk_t'(bus.step_o), 3);
    apply_reset();
    void'(exp_q.pop_back());
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    start_block(rand_blk(), rand_blk());
    wait_done(1'b0, 1'b0);
    finish_block(1, 1'b0, got);

    // Reset while holding in DONE drops valid_o without a handshake.
    start_block(rand_blk(), rand_blk());
    wait_done(1'b0, 1'b0);
    @(negedge clk);
    check("done_hold_valid_o", blk_t'(bus.valid_o), 1);
    apply_reset();
    void'(exp_q.pop_back());
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    check("post_reset_ready_o", blk_t'(bus.ready_o), 1);

    check("scoreboard_drained", blk_t'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
